// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select codes and PC-unit state encoding.
package cpu_pkg;
    localparam logic [2:0] NPC_SEQ  = 3'b000;
    localparam logic [2:0] NPC_BEQ  = 3'b001;
    localparam logic [2:0] NPC_BNE  = 3'b010;
    localparam logic [2:0] NPC_J    = 3'b011;
    localparam logic [2:0] NPC_JAL  = 3'b100;
    localparam logic [2:0] NPC_JR   = 3'b101;
    localparam logic [2:0] NPC_HALT = 3'b110;
    localparam logic [2:0] NPC_ERET = 3'b111;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;
endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection for the RUN state, plus the jal link value (pc+1).
// All arithmetic wraps modulo 2^AW.
module npc_calc
    import cpu_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [2:0]    npc_sel,
    input  logic          zero,
    input  logic [AW-1:0] pc,
    input  logic [AW-1:0] imm,
    input  logic [AW-1:0] busa,
    input  logic [25:0]   jump_addr,
    input  logic [AW-1:0] epc,
    output logic [AW-1:0] npc,
    output logic [AW-1:0] link_addr
);
    logic [AW-1:0] seq_pc;
    logic [AW-1:0] br_pc;
    logic [AW-1:0] jmp_pc;

    assign seq_pc    = pc + AW'(1);
    assign br_pc     = seq_pc + imm;
    assign jmp_pc    = {pc[AW-1:26], jump_addr};
    assign link_addr = seq_pc;

    always_comb begin
        npc = seq_pc;
        case (npc_sel)
            NPC_SEQ:  npc = seq_pc;
            NPC_BEQ:  npc = zero ? br_pc : seq_pc;
            NPC_BNE:  npc = zero ? seq_pc : br_pc;
            NPC_J:    npc = jmp_pc;
            NPC_JAL:  npc = jmp_pc;
            NPC_JR:   npc = busa;
            NPC_HALT: npc = pc;
            NPC_ERET: npc = epc;
            default:  npc = seq_pc;
        endcase
    end
endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC/EPC registers, RUN/HALT state machine, exception entry and ERET.
// Edge priority: rst > unmasked exc_req (taken even when stalled) > en=0 stall > normal sequencing.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [AW-1:0] EXC_VEC  = AW'('h100)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [2:0]    npc_sel,
    input  logic          zero,
    input  logic [AW-1:0] imm,
    input  logic [AW-1:0] busa,
    input  logic [25:0]   jump_addr,
    input  logic          exc_req,
    input  logic          resume,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] npc,
    output logic [AW-1:0] link_addr,
    output logic [AW-1:0] epc,
    output logic          halted,
    output logic          in_exc,
    output logic          exc_taken
);
    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] epc_q, epc_d;
    logic          in_exc_q, in_exc_d;
    logic          exc_taken_q, exc_taken_d;
    logic [AW-1:0] run_npc;

    npc_calc #(.AW(AW)) u_npc_calc (
        .npc_sel   (npc_sel),
        .zero      (zero),
        .pc        (pc_q),
        .imm       (imm),
        .busa      (busa),
        .jump_addr (jump_addr),
        .epc       (epc_q),
        .npc       (run_npc),
        .link_addr (link_addr)
    );

    // While halted the fetch address is frozen, which is also what an exception saves as EPC.
    assign npc = (state_q == ST_HALT) ? pc_q : run_npc;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        epc_d       = epc_q;
        in_exc_d    = in_exc_q;
        exc_taken_d = 1'b0;
        if (exc_req && !in_exc_q) begin
            epc_d       = npc;
            pc_d        = EXC_VEC;
            in_exc_d    = 1'b1;
            state_d     = ST_RUN;
            exc_taken_d = 1'b1;
        end else if (en) begin
            case (state_q)
                ST_RUN: begin
                    pc_d = run_npc;
                    if (npc_sel == NPC_HALT) state_d = ST_HALT;
                    if (npc_sel == NPC_ERET) in_exc_d = 1'b0;
                end
                ST_HALT: begin
                    if (resume) begin
                        state_d = ST_RUN;
                        pc_d    = pc_q + AW'(1);
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            epc_q       <= '0;
            in_exc_q    <= 1'b0;
            exc_taken_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            epc_q       <= epc_d;
            in_exc_q    <= in_exc_d;
            exc_taken_q <= exc_taken_d;
        end
    end

    assign pc        = pc_q;
    assign epc       = epc_q;
    assign halted    = (state_q == ST_HALT);
    assign in_exc    = in_exc_q;
    assign exc_taken = exc_taken_q;
endmodule
